// File: rtl/mac_enc_if.sv
// Header/body FIFO read side, per-port TX FIFO write side and drop counter of mac_enc.
// slave is the encoder's view; master is the environment driving the FIFOs.
interface mac_enc_if;
    logic [118:0] h_fifo_dout;
    logic         h_fifo_empty;
    logic         h_fifo_rden;
    logic [7:0]   b_fifo_dout;
    logic         b_fifo_empty;
    logic         b_fifo_del;
    logic         b_fifo_rden;
    logic [3:0]   o_fifo_afull;
    logic [7:0]   o_fifo_din;
    logic [3:0]   o_fifo_wren;
    logic         o_fifo_del;
    logic [15:0]  drop_cnt;

    // Reads are FWFT: a pop (rden) is honoured on the rising edge where it is high,
    // and only when the matching empty flag is low.
    modport slave (
        input  h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del, o_fifo_afull,
        output h_fifo_rden, b_fifo_rden, o_fifo_din, o_fifo_wren, o_fifo_del, drop_cnt
    );

    modport master (
        output h_fifo_dout, h_fifo_empty, b_fifo_dout, b_fifo_empty, b_fifo_del, o_fifo_afull,
        input  h_fifo_rden, b_fifo_rden, o_fifo_din, o_fifo_wren, o_fifo_del, drop_cnt
    );
endinterface

// File: rtl/mac_enc.sv
// Frame encoder: replays the 14-byte MAC header, then forwards the body (with its
// original FCS) to the masked TX ports; bad or unroutable frames are drained and counted.
module mac_enc (
    input  logic       clk,
    input  logic       arst_n,
    mac_enc_if.slave   bus,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_DRAIN   = 3'd3,
        S_END     = 3'd4
    } state_t;

    state_t         state_q, state_d;
    logic [111:0]   hdr_q, hdr_d;
    logic [3:0]     eff_q, eff_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           h_rden_q, h_rden_d;
    logic [7:0]     din_q, din_d;
    logic [3:0]     wren_q, wren_d;
    logic           del_q, del_d;
    logic [15:0]    drop_q, drop_d;
    logic           b_rden;

    logic [3:0]     in_eff;
    logic           in_fcs_ok;

    // Never send a frame back out of the port it arrived on.
    assign in_eff    = bus.h_fifo_dout[118:115] & ~(4'b0001 << bus.h_fifo_dout[113:112]);
    assign in_fcs_ok = bus.h_fifo_dout[114];

    always_comb begin
        state_d  = state_q;
        hdr_d    = hdr_q;
        eff_d    = eff_q;
        cnt_d    = cnt_q;
        h_rden_d = 1'b0;
        din_d    = din_q;
        wren_d   = 4'b0000;
        del_d    = 1'b0;
        drop_d   = drop_q;
        b_rden   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.h_fifo_empty && ((bus.o_fifo_afull & in_eff) == 4'b0000)) begin
                    // The entry is captured now; the pop lands one cycle later, which is
                    // harmless because the next header is not looked at before S_IDLE.
                    h_rden_d = 1'b1;
                    hdr_d    = bus.h_fifo_dout[111:0];
                    eff_d    = in_eff;
                    cnt_d    = 4'd0;
                    state_d  = (in_fcs_ok && (in_eff != 4'b0000)) ? S_HEADER : S_DRAIN;
                end
            end
            S_HEADER: begin
                din_d  = hdr_q[111:104];
                wren_d = eff_q;
                hdr_d  = {hdr_q[103:0], 8'h00};
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!bus.b_fifo_empty) begin
                    b_rden = 1'b1;
                    din_d  = bus.b_fifo_dout;
                    wren_d = eff_q;
                    del_d  = bus.b_fifo_del;
                    if (bus.b_fifo_del) begin
                        state_d = S_END;
                    end
                end
            end
            S_DRAIN: begin
                if (!bus.b_fifo_empty) begin
                    b_rden = 1'b1;
                    if (bus.b_fifo_del) begin
                        drop_d  = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                        state_d = S_END;
                    end
                end
            end
            S_END: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_END;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= S_IDLE;
            hdr_q    <= '0;
            eff_q    <= 4'b0000;
            cnt_q    <= 4'd0;
            h_rden_q <= 1'b0;
            din_q    <= 8'h00;
            wren_q   <= 4'b0000;
            del_q    <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            hdr_q    <= hdr_d;
            eff_q    <= eff_d;
            cnt_q    <= cnt_d;
            h_rden_q <= h_rden_d;
            din_q    <= din_d;
            wren_q   <= wren_d;
            del_q    <= del_d;
            drop_q   <= drop_d;
        end
    end

    assign bus.h_fifo_rden = h_rden_q;
    assign bus.b_fifo_rden = b_rden;
    assign bus.o_fifo_din  = din_q;
    assign bus.o_fifo_wren = wren_q;
    assign bus.o_fifo_del  = del_q;
    assign bus.drop_cnt    = drop_q;
    assign state_o         = state_q;
endmodule

// File: tb/tb_mac_enc.sv
// Directed bench for mac_enc: FWFT FIFO models feed frames, a scoreboard checks every
// TX write against hand-built expected bytes, masks and delimiters.
module tb_mac_enc;
    logic       clk;
    logic       arst_n;
    logic [2:0] state;

    mac_enc_if bus();

    mac_enc dut (
        .clk     (clk),
        .arst_n  (arst_n),
        .bus     (bus),
        .state_o (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [118:0] hq[$];
    logic [8:0]   bq[$];
    logic [12:0]  exp_q[$];

    logic h_pop = 1'b0;
    logic b_pop = 1'b0;
    logic stall_seen = 1'b0;
    int   h_pops = 0;
    int   b_pops = 0;
    int   wr_cnt = 0;
    int   stall_hits = 0;
    int   stall_at = -1;
    int   stall_len = 0;
    int   stall_cnt = 0;

    localparam logic [111:0] HDR = {48'h111213141516, 48'h212223242526, 16'h0800};

    // Capture strobes on the edge the DUT acts on them.
    always @(posedge clk) begin
        h_pop      = bus.h_fifo_rden;
        b_pop      = bus.b_fifo_rden;
        stall_seen = bus.b_fifo_empty && (state == 3'd2);
    end

    // FWFT FIFO models: apply last edge's pops, then present the new heads.
    always @(negedge clk) begin
        if (h_pop && hq.size() > 0) begin
            void'(hq.pop_front());
            h_pops++;
        end
        if (b_pop && bq.size() > 0) begin
            void'(bq.pop_front());
            b_pops++;
        end
        bus.h_fifo_empty = (hq.size() == 0);
        bus.h_fifo_dout  = (hq.size() == 0) ? '0 : hq[0];
        if (stall_cnt < stall_len && b_pops == stall_at) begin
            stall_cnt++;
            bus.b_fifo_empty = 1'b1;
            bus.b_fifo_dout  = 8'hEE;
            bus.b_fifo_del   = 1'b1;
        end else begin
            bus.b_fifo_empty = (bq.size() == 0);
            bus.b_fifo_dout  = (bq.size() == 0) ? 8'h00 : bq[0][7:0];
            bus.b_fifo_del   = (bq.size() == 0) ? 1'b0 : bq[0][8];
        end
    end

    // Scoreboard on the TX side.
    always @(negedge clk) begin
        if (stall_seen) begin
            stall_hits++;
            check("stall_wren", 32'(bus.o_fifo_wren), 32'd0);
        end
        if (bus.o_fifo_del && bus.o_fifo_wren == 4'b0000) begin
            check("del_no_wren", 32'(bus.o_fifo_del), 32'd0);
        end
        if (bus.o_fifo_wren != 4'b0000) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                check("wr_no_exp", 32'(exp_q.size()), 32'd1);
            end else begin
                check("wr_data", 32'({bus.o_fifo_wren, bus.o_fifo_del, bus.o_fifo_din}),
                      32'(exp_q.pop_front()));
            end
        end
    end

    task automatic push_frame(input logic [3:0] mask, input logic fcs, input logic [1:0] src,
                              input logic [3:0] exp_wren, input logic [7:0] seed);
        logic [7:0] b;
        hq.push_back({mask, fcs, src, HDR});
        if (exp_wren != 4'b0000) begin
            for (int i = 0; i < 14; i++) begin
                b = HDR[111 - 8*i -: 8];
                exp_q.push_back({exp_wren, 1'b0, b});
            end
        end
        for (int i = 0; i < 50; i++) begin
            b = seed + 8'(i);
            bq.push_back({(i == 49), b});
            if (exp_wren != 4'b0000) exp_q.push_back({exp_wren, (i == 49), b});
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            @(negedge clk);
            if (hq.size() == 0 && bq.size() == 0 && state == 3'd0) done = 1'b1;
        end
        @(negedge clk);
        check("idle_timeout", 32'(done), 32'd1);
    endtask

    task automatic end_of_frame(input int b_base, input int exp_drop);
        check("exp_left", 32'(exp_q.size()), 32'd0);
        check("body_pops", 32'(b_pops - b_base), 32'd50);
        check("drop_cnt", 32'(bus.drop_cnt), 32'(exp_drop));
    endtask

    int b_base;
    int h_base;
    int w_base;
    bit reached;

    initial begin
        arst_n = 1'b0;
        bus.o_fifo_afull = 4'b0000;
        bus.h_fifo_empty = 1'b1;
        bus.h_fifo_dout  = '0;
        bus.b_fifo_empty = 1'b1;
        bus.b_fifo_dout  = 8'h00;
        bus.b_fifo_del   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_h_rden", 32'(bus.h_fifo_rden), 32'd0);
        check("rst_b_rden", 32'(bus.b_fifo_rden), 32'd0);
        check("rst_din", 32'(bus.o_fifo_din), 32'd0);
        check("rst_wren", 32'(bus.o_fifo_wren), 32'd0);
        check("rst_del", 32'(bus.o_fifo_del), 32'd0);
        check("rst_drop", 32'(bus.drop_cnt), 32'd0);
        arst_n = 1'b1;
        @(negedge clk);

        // Good frame to port 1 only.
        b_base = b_pops;
        push_frame(4'b0010, 1'b1, 2'd0, 4'b0010, 8'h40);
        wait_idle(300);
        end_of_frame(b_base, 0);

        // Same frame with bad FCS: drained, counted.
        b_base = b_pops;
        push_frame(4'b0010, 1'b0, 2'd0, 4'b0000, 8'h50);
        wait_idle(300);
        end_of_frame(b_base, 1);

        // Only destination is the ingress port.
        b_base = b_pops;
        push_frame(4'b0001, 1'b1, 2'd0, 4'b0000, 8'h60);
        wait_idle(300);
        end_of_frame(b_base, 2);

        // Broadcast from port 2; afull on the excluded port does not block, later afull ignored.
        bus.o_fifo_afull = 4'b0100;
        b_base = b_pops;
        push_frame(4'b1111, 1'b1, 2'd2, 4'b1011, 8'h70);
        repeat (5) @(negedge clk);
        bus.o_fifo_afull = 4'b1111;
        wait_idle(300);
        bus.o_fifo_afull = 4'b0000;
        end_of_frame(b_base, 2);

        // Selected port almost full: hold in idle without popping.
        bus.o_fifo_afull = 4'b0010;
        h_base = h_pops;
        b_base = b_pops;
        push_frame(4'b0011, 1'b1, 2'd0, 4'b0010, 8'h80);
        repeat (10) @(negedge clk);
        check("blk_h_pops", 32'(h_pops - h_base), 32'd0);
        check("blk_state", 32'(state), 32'd0);
        check("blk_wr", 32'(exp_q.size()), 32'd64);
        bus.o_fifo_afull = 4'b0000;
        wait_idle(300);
        end_of_frame(b_base, 2);
        check("blk_h_pop_once", 32'(h_pops - h_base), 32'd1);

        // Body FIFO runs dry for 5 cycles mid-payload.
        b_base = b_pops;
        stall_at = b_pops + 20;
        stall_len = 5;
        push_frame(4'b0100, 1'b1, 2'd1, 4'b0100, 8'h90);
        wait_idle(300);
        end_of_frame(b_base, 2);
        check("stall_hits", 32'(stall_hits), 32'd5);

        // Reset mid-payload abandons the frame.
        w_base = wr_cnt;
        push_frame(4'b1000, 1'b1, 2'd0, 4'b1000, 8'hA0);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (wr_cnt - w_base >= 30) reached = 1'b1;
        end
        check("mid_reached", 32'(reached), 32'd1);
        #2 arst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_wren", 32'(bus.o_fifo_wren), 32'd0);
        check("mid_rst_del", 32'(bus.o_fifo_del), 32'd0);
        check("mid_rst_din", 32'(bus.o_fifo_din), 32'd0);
        check("mid_rst_b_rden", 32'(bus.b_fifo_rden), 32'd0);
        check("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
        hq.delete();
        bq.delete();
        exp_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_wr", 32'(exp_q.size()), 32'd0);

        // Recovery frame after reset.
        b_base = b_pops;
        push_frame(4'b0001, 1'b1, 2'd3, 4'b0001, 8'hB0);
        wait_idle(300);
        end_of_frame(b_base, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac_enc.md
MAC_ENC -- requirements
Module: mac_enc

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 arst_n  in  1  reset, asynchronous, active-low.
REQ-003 h_fifo_dout  in  119  header entry {dst_mask[3:0], fcs_correct, src_port[1:0], dst_mac[47:0], src_mac[47:0], type[15:0]}; first-word-fall-through (FWFT).
REQ-004 h_fifo_empty  in  1  header FIFO empty.
REQ-005 h_fifo_rden  out  1  one-cycle pop of header FIFO.
REQ-006 b_fifo_dout  in  8  body byte (payload followed by original 4 FCS bytes), FWFT.
REQ-007 b_fifo_empty  in  1  body FIFO empty.
REQ-008 b_fifo_del  in  1  current b_fifo_dout is last byte of frame.
REQ-009 b_fifo_rden  out  1  pop body FIFO.
REQ-010 o_fifo_afull  in  4  per-port TX FIFO almost-full; low guarantees space for 1,518 B.
REQ-011 o_fifo_din  out  8  byte shared by all four TX FIFOs.
REQ-012 o_fifo_wren  out  4  per-port write enable.
REQ-013 o_fifo_del  out  1  delimiter, qualifies last written byte.
REQ-014 drop_cnt  out  16  count of dropped frames.

Function
REQ-015 States: S_IDLE, S_HEADER, S_PAYLOAD, S_DRAIN, S_END; any other encoding -> S_END next cycle.
REQ-016 Effective mask eff = dst_mask & ~onehot(src_port); hairpin to ingress port is never performed.
REQ-017 S_IDLE: when ~h_fifo_empty and (o_fifo_afull & eff) == 0, latch entry, pulse h_fifo_rden 1 cycle, clear byte counter; next state S_HEADER if fcs_correct=1 and eff!=0, else S_DRAIN.
REQ-018 S_IDLE with h_fifo_empty=1 or any selected port afull: no pops, no writes, remain.
REQ-019 S_HEADER: one byte per cycle, order dst_mac[47:40] first through type[7:0] last (14 bytes); o_fifo_din registered, o_fifo_wren = eff, o_fifo_del=0; after 14th byte -> S_PAYLOAD.
REQ-020 Header bytes are emitted without dependence on body FIFO state; output write latency is one cycle from state/counter to registered outputs.
REQ-021 S_PAYLOAD: if ~b_fifo_empty, assert b_fifo_rden, register b_fifo_dout to o_fifo_din, o_fifo_wren = eff, o_fifo_del = b_fifo_del; on del -> S_END.
REQ-022 S_PAYLOAD with b_fifo_empty=1: stall, b_fifo_rden=0, o_fifo_wren=0, state held.
REQ-023 Body bytes including original FCS are forwarded unchanged; no CRC is recomputed.
REQ-024 S_DRAIN: pop body bytes while ~b_fifo_empty with o_fifo_wren=0; on del popped -> S_END, drop_cnt += 1.
REQ-025 drop_cnt saturates at 16'hFFFF.
REQ-026 S_END: one cycle; all strobes (h_fifo_rden, b_fifo_rden, o_fifo_wren, o_fifo_del) 0; -> S_IDLE.
REQ-027 o_fifo_afull changes after frame start are ignored until S_IDLE.
REQ-028 b_fifo_del with b_fifo_empty=1 is ignored.
REQ-029 Frames are processed strictly in header FIFO order; one frame in flight.

Reset
REQ-030 arst_n low, at any time including mid-frame: STATE=S_IDLE, counters 0, h_fifo_rden=0, b_fifo_rden=0, o_fifo_din=8'h00, o_fifo_wren=4'b0000, o_fifo_del=0, drop_cnt=0.
REQ-031 Partially sent frame is abandoned on reset; no del is emitted for it.

Verification
REQ-032 Header {4'b0010, 1, 2'd0, DA=11..16, SA=21..26, type 0800}, body 46 B + 4 FCS with del on last -> port1 wren only, 64 bytes 11..16,21..26,08,00,body, del on 64th, drop_cnt=0.
REQ-033 Same frame, fcs_correct=0 -> zero TX writes, 50 body pops, drop_cnt=1.
REQ-034 dst_mask=4'b0001, src_port=0 -> eff=0 -> drained, drop_cnt increments.
REQ-035 dst_mask=4'b1111, src_port=2, o_fifo_afull=4'b0100 -> starts, wren=4'b1011 for all bytes.
REQ-036 dst_mask=4'b0011, o_fifo_afull[1]=1 -> stays S_IDLE, no h_fifo_rden until afull[1]=0.
REQ-037 Body empty for 5 cycles mid-payload -> wren low for those cycles, byte order intact; arst_n pulse mid-payload -> all outputs reset values next edge.
